// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, absorbs the one-cycle registered read latency of
// instruction memory, and presents {pc, instr} to decode through a small FIFO queue.
module fetch_unit #(
    parameter int                ADDR_W    = 16,
    parameter int                INSTR_W   = 24,
    parameter int                MEM_DEPTH = 32768,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                Q_DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [INSTR_W-1:0] instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int                PW      = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int                CW      = $clog2(Q_DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [INSTR_W-1:0] q_instr [Q_DEPTH];
    logic [ADDR_W-1:0]  q_pc    [Q_DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CW:0]        reserved;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        if (p == PW'(Q_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign iaddr     = pc;
    assign out_valid = (count != '0);
    assign out_instr = q_instr[head];
    assign out_pc    = q_pc[head];
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Every issued word already owns a queue slot, so the queue can never overflow;
    // when no slot is left the PC simply holds (the implicit stall state).
    assign reserved  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = !redirect_valid && (reserved < (CW+1)'(Q_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC & PC_MASK;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Dropping inflight discards the word that memory returns next cycle.
            pc       <= redirect_pc & PC_MASK;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
                pc          <= (pc + ADDR_W'(1)) & PC_MASK;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                q_instr[tail] <= instr;
                q_pc[tail]    <= inflight_pc;
                tail          <= bump(tail);
            end
            if (pop) begin
                head <= bump(head);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a registered memory model plus a scoreboard that
// expects consecutive PCs (mod MEM_DEPTH) from each reset/redirect target.
module tb_fetch_unit;

    localparam int          ADDR_W  = 16;
    localparam int          INSTR_W = 24;
    localparam logic [15:0] MASK    = 16'h7FFF;

    logic               clk;
    logic               rst;
    logic [ADDR_W-1:0]  iaddr;
    logic [INSTR_W-1:0] instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    logic [INSTR_W-1:0] mem [32768];
    logic [15:0]        exp_pc;
    int                 tests;
    int                 fails;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .iaddr          (iaddr),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory with one cycle of registered read latency.
    always @(posedge clk) begin
        instr <= mem[iaddr[14:0]];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_mem(input bit ident);
        for (int k = 0; k < 32768; k++) begin
            mem[k] = ident ? 24'(k) : 24'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (iaddr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_iaddr: got %h expected 0000", iaddr);
        end
        tests++;
        if (out_pc !== 16'h0000 || out_instr !== 24'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got pc %h instr %h expected 0/0", out_pc, out_instr);
        end
        exp_pc = 16'h0000;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_latency: got valid %b one cycle after release expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_stream(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem[exp_pc[14:0]]) begin
                fails++;
                $display("[TB] FAIL stream: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         out_valid, out_pc, out_instr, exp_pc, mem[exp_pc[14:0]]);
            end
            exp_pc = (exp_pc + 16'd1) & MASK;
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem[exp_pc[14:0]]) begin
                fails++;
                $display("[TB] FAIL hold: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         out_valid, out_pc, out_instr, exp_pc, mem[exp_pc[14:0]]);
            end
            tick();
        end
        tests++;
        if (iaddr !== ((exp_pc + 16'd2) & MASK)) begin
            fails++;
            $display("[TB] FAIL stall_iaddr: got %h expected %h", iaddr, (exp_pc + 16'd2) & MASK);
        end
    endtask

    task automatic test_redirect(input logic [15:0] target, input bit with_pop);
        out_ready = with_pop;
        redirect_valid = 1'b1;
        redirect_pc = target;
        if (with_pop) begin
            tests++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                fails++;
                $display("[TB] FAIL redirect_pop: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, exp_pc);
            end
        end
        exp_pc = target & MASK;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || iaddr !== exp_pc) begin
            fails++;
            $display("[TB] FAIL redirect_bubble1: got v=%b iaddr=%h expected v=0 iaddr=%h", out_valid, iaddr, exp_pc);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL redirect_bubble2: got v=%b expected 0", out_valid);
        end
        tick();
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        repeat (4) tick();
        tests++;
        if (out_valid !== 1'b1 || iaddr !== ((exp_pc + 16'd2) & MASK)) begin
            fails++;
            $display("[TB] FAIL full_before_redirect: got v=%b iaddr=%h expected v=1 iaddr=%h",
                     out_valid, iaddr, (exp_pc + 16'd2) & MASK);
        end
        test_redirect(16'h0100, 1'b0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h1234;
        tick();
        redirect_pc = 16'h2000;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_first_bubble: got v=%b expected 0", out_valid);
        end
        exp_pc = exp_pc + 16'd1;
        test_redirect(16'h2000, 1'b0);
    endtask

    task automatic test_random(input int n);
        int          since_redir;
        bit          hold;
        logic [15:0] prev_pc;
        logic [23:0] prev_instr;
        bit          r;
        bit          rv;
        logic [15:0] rpc;
        since_redir = 3;
        hold = 1'b0;
        prev_pc = '0;
        prev_instr = '0;
        for (int i = 0; i < n; i++) begin
            r   = ($urandom % 10) < 7;
            rv  = ($urandom % 20) == 0;
            rpc = 16'($urandom);
            out_ready = r;
            redirect_valid = rv;
            redirect_pc = rpc;
            if (since_redir < 2) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL rand_bubble: got v=%b expected 0 at iter %0d", out_valid, i);
                end
            end else if (since_redir == 2) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL rand_refill: got v=%b expected 1 at iter %0d", out_valid, i);
                end
            end
            if (hold) begin
                tests++;
                if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
                    fails++;
                    $display("[TB] FAIL rand_stable: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                             out_valid, out_pc, out_instr, prev_pc, prev_instr);
                end
            end
            if (out_valid === 1'b1 && r) begin
                tests++;
                if (out_pc !== exp_pc || out_instr !== mem[exp_pc[14:0]]) begin
                    fails++;
                    $display("[TB] FAIL rand_order: got pc=%h instr=%h expected pc=%h instr=%h",
                             out_pc, out_instr, exp_pc, mem[exp_pc[14:0]]);
                end
                exp_pc = (exp_pc + 16'd1) & MASK;
            end
            if (rv) begin
                exp_pc = rpc & MASK;
                since_redir = 0;
                hold = 1'b0;
            end else begin
                if (since_redir < 3) since_redir++;
                hold = (out_valid === 1'b1) && !r;
                prev_pc = out_pc;
                prev_instr = out_instr;
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_pc = '0;
        fill_mem(1'b1);
        test_reset();
        test_stream(12);
        fill_mem(1'b0);
        test_reset();
        test_backpressure();
        test_stream(6);
        test_redirect_full();
        test_stream(6);
        test_redirect(16'h7FFE, 1'b1);
        test_stream(6);
        test_redirect(16'h8005, 1'b1);
        test_stream(4);
        test_back_to_back();
        test_stream(4);
        test_reset();
        test_stream(4);
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
